// File: rtl/loop_addr_sequencer_if.sv
// Command/response channel of the loop address sequencer.
//
// Handshake rules (one place, applies to every user of this interface):
//   - A command transfers on a rising clk edge where cmd_valid && cmd_ready.
//     The master holds cmd_op/cmd_loop/cmd_pc stable while cmd_valid is high.
//   - rsp_valid is a single-cycle pulse with no back-pressure. rsp_jump,
//     rsp_pc and rsp_done are meaningful only while rsp_valid is high and
//     are driven to 0 otherwise.
//
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 START, 01 END, 10 ABORT, 11 reserved
//   cmd_loop             loop slot used by START
//   cmd_pc               PC of the START instruction
//   rsp_valid            response pulse
//   rsp_jump/rsp_pc      jump request and target
//   rsp_done             loop stack became (or already was) empty
interface loop_addr_sequencer_if #(
  parameter int LOOP_DEPTH = 8,
  parameter int PC_W       = 16
);
  localparam int LW = $clog2(LOOP_DEPTH);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [LW-1:0]   cmd_loop;
  logic [PC_W-1:0] cmd_pc;
  logic            rsp_valid;
  logic            rsp_jump;
  logic [PC_W-1:0] rsp_pc;
  logic            rsp_done;

  modport master (
    output cmd_valid, cmd_op, cmd_loop, cmd_pc,
    input  cmd_ready, rsp_valid, rsp_jump, rsp_pc, rsp_done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_loop, cmd_pc,
    output cmd_ready, rsp_valid, rsp_jump, rsp_pc, rsp_done
  );
endinterface

// File: rtl/loop_addr_sequencer.sv
// Hardware loop stack with per-loop address generation for NUM_ADDR channels.
// START pushes a loop frame (slot, pc, iteration index, address snapshot);
// END either advances every channel address by the top loop's stride and
// requests a jump back to pc+1, or pops the frame and restores the snapshot.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-low reset
//   cfg_we/...      loop slot write: count and per-channel stride
//   cfg_base_we/... per-channel base address write (also loads addr)
//   cmd_if          command/response channel (slave side)
//   addr            current per-channel addresses, channel c at [c*ADDR_W +: ADDR_W]
//   depth           current stack depth
//   loop_var        iteration index of the top frame, 0 when empty
//   err             sticky error flag, cleared only by reset
//   dbg_state_o     FSM state (0 IDLE, 1 EXEC, 2 RESP)
module loop_addr_sequencer #(
  parameter int LOOP_DEPTH = 8,
  parameter int NUM_ADDR   = 4,
  parameter int ADDR_W     = 18,
  parameter int CNT_W      = 16,
  parameter int PC_W       = 16,
  localparam int LW        = $clog2(LOOP_DEPTH),
  localparam int AW        = NUM_ADDR * ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [LW-1:0]        cfg_loop,
  input  logic [CNT_W-1:0]     cfg_count,
  input  logic [AW-1:0]        cfg_stride,
  input  logic                 cfg_base_we,
  input  logic [AW-1:0]        cfg_base,
  loop_addr_sequencer_if.slave cmd_if,
  output logic [AW-1:0]        addr,
  output logic [LW:0]          depth,
  output logic [CNT_W-1:0]     loop_var,
  output logic                 err,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [1:0]  OP_START = 2'b00;
  localparam logic [1:0]  OP_END   = 2'b01;
  localparam logic [1:0]  OP_ABORT = 2'b10;
  localparam logic [LW:0] DEPTH_FULL = (LW+1)'(LOOP_DEPTH);
  localparam logic [LW:0] DEPTH_ONE  = (LW+1)'(1);

  state_t          state_q;
  logic [1:0]      op_q;
  logic [LW-1:0]   loop_q;
  logic [PC_W-1:0] pc_q;

  logic [CNT_W-1:0] count_q  [LOOP_DEPTH];
  logic [AW-1:0]    stride_q [LOOP_DEPTH];
  logic [AW-1:0]    base_q;
  logic [AW-1:0]    addr_q;

  logic [LW-1:0]    stk_loop_q [LOOP_DEPTH];
  logic [PC_W-1:0]  stk_pc_q   [LOOP_DEPTH];
  logic [CNT_W-1:0] stk_var_q  [LOOP_DEPTH];
  logic [AW-1:0]    stk_addr_q [LOOP_DEPTH];
  logic [LW:0]      depth_q;

  logic            err_q;
  logic            rsp_valid_q;
  logic            rsp_jump_q;
  logic            rsp_done_q;
  logic [PC_W-1:0] rsp_pc_q;

  logic             stack_empty;
  logic             stack_full;
  logic             cfg_ok;
  logic             last_iter;
  logic [LW-1:0]    top_idx;
  logic [LW-1:0]    top_loop;
  logic [CNT_W-1:0] top_var;
  logic [AW-1:0]    addr_step_d;

  always_comb begin
    stack_empty = (depth_q == '0);
    stack_full  = (depth_q == DEPTH_FULL);
    // Config is only safe while nothing is in flight and no frame refers to it.
    cfg_ok      = (state_q == S_IDLE) && stack_empty;
    // Wraps to the last slot when empty; every user guards on stack_empty.
    top_idx     = LW'(depth_q - DEPTH_ONE);
    top_loop    = stk_loop_q[top_idx];
    top_var     = stk_var_q[top_idx];
    // One bit wider so var+1 cannot wrap; ">=" also retires a frame whose count shrank.
    last_iter   = (({1'b0, top_var} + (CNT_W+1)'(1)) >= {1'b0, count_q[top_loop]});
    addr_step_d = '0;
    for (int c = 0; c < NUM_ADDR; c++) begin
      // Per-channel sum truncates to ADDR_W: modulo arithmetic, no error on wrap.
      addr_step_d[c*ADDR_W +: ADDR_W] = addr_q[c*ADDR_W +: ADDR_W]
                                      + stride_q[top_loop][c*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      loop_q      <= '0;
      pc_q        <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_jump_q  <= 1'b0;
      rsp_done_q  <= 1'b0;
      rsp_pc_q    <= '0;
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        count_q[i]    <= '0;
        stride_q[i]   <= '0;
        stk_loop_q[i] <= '0;
        stk_pc_q[i]   <= '0;
        stk_var_q[i]  <= '0;
        stk_addr_q[i] <= '0;
      end
    end else begin
      // Config writes land on the accept edge, so a START accepted together
      // with a slot write executes one cycle later against the new count.
      if (cfg_we) begin
        if (cfg_ok) begin
          count_q[cfg_loop]  <= cfg_count;
          stride_q[cfg_loop] <= cfg_stride;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (cfg_base_we) begin
        if (cfg_ok) begin
          base_q <= cfg_base;
          addr_q <= cfg_base;
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_if.cmd_valid) begin
            op_q    <= cmd_if.cmd_op;
            loop_q  <= cmd_if.cmd_loop;
            pc_q    <= cmd_if.cmd_pc;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_jump_q  <= 1'b0;
          rsp_done_q  <= 1'b0;
          rsp_pc_q    <= '0;
          case (op_q)
            OP_START: begin
              if (stack_full || (count_q[loop_q] == '0)) begin
                err_q <= 1'b1;
              end else begin
                stk_loop_q[depth_q[LW-1:0]] <= loop_q;
                stk_pc_q[depth_q[LW-1:0]]   <= pc_q;
                stk_var_q[depth_q[LW-1:0]]  <= '0;
                stk_addr_q[depth_q[LW-1:0]] <= addr_q;
                depth_q                     <= depth_q + DEPTH_ONE;
              end
            end
            OP_END: begin
              if (stack_empty) begin
                err_q      <= 1'b1;
                rsp_done_q <= 1'b1;
              end else if (!last_iter) begin
                stk_var_q[top_idx] <= top_var + CNT_W'(1);
                addr_q             <= addr_step_d;
                rsp_jump_q         <= 1'b1;
                rsp_pc_q           <= stk_pc_q[top_idx] + PC_W'(1);
              end else begin
                depth_q    <= depth_q - DEPTH_ONE;
                addr_q     <= stk_addr_q[top_idx];
                rsp_done_q <= (depth_q == DEPTH_ONE);
              end
            end
            OP_ABORT: begin
              depth_q    <= '0;
              addr_q     <= base_q;
              rsp_done_q <= 1'b1;
            end
            default: begin
              err_q <= 1'b1;
            end
          endcase
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_jump_q  <= 1'b0;
          rsp_done_q  <= 1'b0;
          rsp_pc_q    <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = (state_q == S_IDLE);
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_jump  = rsp_jump_q;
  assign cmd_if.rsp_pc    = rsp_pc_q;
  assign cmd_if.rsp_done  = rsp_done_q;
  assign addr             = addr_q;
  assign depth            = depth_q;
  assign loop_var         = stack_empty ? '0 : top_var;
  assign err              = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_loop_addr_sequencer.sv
module tb_loop_addr_sequencer;
  localparam int LOOP_DEPTH = 8;
  localparam int NUM_ADDR   = 4;
  localparam int ADDR_W     = 18;
  localparam int CNT_W      = 16;
  localparam int PC_W       = 16;
  localparam int LW         = 3;
  localparam int AW         = NUM_ADDR * ADDR_W;
  localparam int RW         = PC_W + 2;
  localparam int START = 0, ENDC = 1, ABORT = 2, RSVD = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_we      = 1'b0;
  logic [LW-1:0]    cfg_loop    = '0;
  logic [CNT_W-1:0] cfg_count   = '0;
  logic [AW-1:0]    cfg_stride  = '0;
  logic             cfg_base_we = 1'b0;
  logic [AW-1:0]    cfg_base    = '0;
  logic [AW-1:0]    addr;
  logic [LW:0]      depth;
  logic [CNT_W-1:0] loop_var;
  logic             err;
  logic [1:0]       dbg_state;

  loop_addr_sequencer_if #(.LOOP_DEPTH(LOOP_DEPTH), .PC_W(PC_W)) cmd_if ();

  loop_addr_sequencer #(
    .LOOP_DEPTH(LOOP_DEPTH), .NUM_ADDR(NUM_ADDR), .ADDR_W(ADDR_W),
    .CNT_W(CNT_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_loop(cfg_loop), .cfg_count(cfg_count), .cfg_stride(cfg_stride),
    .cfg_base_we(cfg_base_we), .cfg_base(cfg_base),
    .cmd_if(cmd_if),
    .addr(addr), .depth(depth), .loop_var(loop_var), .err(err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] lin(input int v, input int k);
    logic [AW-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_ADDR; c++) r[c*ADDR_W +: ADDR_W] = ADDR_W'(v + c * k);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_slot(input int s, input int cnt, input logic [AW-1:0] st);
    cfg_we = 1'b1; cfg_loop = LW'(s); cfg_count = CNT_W'(cnt); cfg_stride = st;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_bases(input logic [AW-1:0] b);
    cfg_base_we = 1'b1; cfg_base = b;
    @(posedge clk); #1;
    cfg_base_we = 1'b0;
  endtask

  // Issues one command, checks response latency and contents; returns in the
  // cycle after RESP (back in IDLE) with all state updates visible.
  task automatic do_cmd(input string tag, input int op, input int lp, input int pc,
                        input int ej, input int epc, input int ed);
    int t;
    logic [RW-1:0] e;
    exp_q.push_back({1'(ej), 1'(ed), PC_W'(epc)});
    t = 0;
    while (!cmd_if.cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    check({tag, "_ready"}, cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'(op);
    cmd_if.cmd_loop = LW'(lp); cmd_if.cmd_pc = PC_W'(pc);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    check({tag, "_no_early_rsp"}, cmd_if.rsp_valid, 0);
    @(posedge clk); #1;
    check({tag, "_rsp_valid"}, cmd_if.rsp_valid, 1);
    e = exp_q.pop_front();
    check({tag, "_rsp"}, {cmd_if.rsp_jump, cmd_if.rsp_done, cmd_if.rsp_pc}, e);
    @(posedge clk); #1;
    check({tag, "_rsp_idle"}, {cmd_if.rsp_valid, cmd_if.rsp_jump, cmd_if.rsp_done, cmd_if.rsp_pc}, 0);
  endtask

  // ---------------- vector table ----------------
  // kind 0: command (a=op b=slot c=pc) then check response and state
  // kind 1: slot config (a=slot b=count c=stride; channel k gets c*(k+1))
  // kind 2: base config (a=base; channel k gets a+k)
  typedef struct {
    int kind; int a; int b; int c;
    int ej; int epc; int ed;
    int ea0; int ea1; int edep; int evar; int eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int kind, input int a, input int b, input int c,
                              input int ej, input int epc, input int ed, input int ea0,
                              input int ea1, input int edep, input int evar, input int eerr);
    vec_t v;
    v.kind = kind; v.a = a; v.b = b; v.c = c; v.ej = ej; v.epc = epc; v.ed = ed;
    v.ea0 = ea0; v.ea1 = ea1; v.edep = edep; v.evar = evar; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.cmd_loop = '0; cmd_if.cmd_pc = '0;

    // Single loop: count 3, stride 2
    tbl.push_back(mk(1, 0, 3, 2,       0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0,       0, 0, 0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, START, 0, 6,   0, 0, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    1, 7, 0,   2, 5, 1, 1, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    1, 7, 0,   4, 9, 1, 2, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    0, 0, 1,   0, 1, 0, 0, 0));
    // Nested: slot0 count 2 stride 16, slot1 count 2 stride 1, base 100
    tbl.push_back(mk(1, 0, 2, 16,      0, 0, 0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 1,       0, 0, 0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 100, 0, 0,     0, 0, 0, 100, 101, 0, 0, 0));
    tbl.push_back(mk(0, START, 0, 10,  0, 0, 0, 100, 101, 1, 0, 0));
    tbl.push_back(mk(0, START, 1, 20,  0, 0, 0, 100, 101, 2, 0, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    1, 21, 0, 101, 103, 2, 1, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    0, 0, 0, 100, 101, 1, 0, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    1, 11, 0, 116, 133, 1, 1, 0));
    tbl.push_back(mk(0, START, 1, 20,  0, 0, 0, 116, 133, 2, 0, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    1, 21, 0, 117, 135, 2, 1, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    0, 0, 0, 116, 133, 1, 1, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    0, 0, 1, 100, 101, 0, 0, 0));
    // ABORT with a live frame, then START on a slot with count 0
    tbl.push_back(mk(0, START, 0, 30,  0, 0, 0, 100, 101, 1, 0, 0));
    tbl.push_back(mk(0, ENDC, 0, 0,    1, 31, 0, 116, 133, 1, 1, 0));
    tbl.push_back(mk(0, ABORT, 0, 0,   0, 0, 1, 100, 101, 0, 0, 0));
    tbl.push_back(mk(0, START, 2, 40,  0, 0, 0, 100, 101, 0, 0, 1));

    // ---------------- reset state ----------------
    #3;
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_outs", {cmd_if.rsp_valid, cmd_if.rsp_jump, cmd_if.rsp_done, cmd_if.rsp_pc}, 0);
    check("rst_state", {addr, depth, loop_var, err, dbg_state}, 0);
    do_reset();

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      case (tbl[i].kind)
        1: cfg_slot(tbl[i].a, tbl[i].b, lin(tbl[i].c, tbl[i].c));
        2: cfg_bases(lin(tbl[i].a, 1));
        default: do_cmd(tag, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ej, tbl[i].epc, tbl[i].ed);
      endcase
      check({tag, "_addr0"}, addr[0 +: ADDR_W], ADDR_W'(tbl[i].ea0));
      check({tag, "_addr1"}, addr[ADDR_W +: ADDR_W], ADDR_W'(tbl[i].ea1));
      check({tag, "_depth"}, depth, tbl[i].edep);
      check({tag, "_var"}, loop_var, tbl[i].evar);
      check({tag, "_err"}, err, tbl[i].eerr);
    end

    // ---------------- reserved op ----------------
    do_reset();
    do_cmd("rsvd", RSVD, 0, 0, 0, 0, 0);
    check("rsvd_err", err, 1);
    check("rsvd_depth", depth, 0);

    // ---------------- stack overflow, ABORT, END on empty ----------------
    do_reset();
    cfg_slot(0, 5, lin(1, 0));
    for (int i = 0; i < LOOP_DEPTH; i++) do_cmd($sformatf("fill%0d", i), START, 0, i, 0, 0, 0);
    check("fill_depth", depth, LOOP_DEPTH);
    check("fill_err", err, 0);
    do_cmd("ovf", START, 0, 99, 0, 0, 0);
    check("ovf_err", err, 1);
    check("ovf_depth", depth, LOOP_DEPTH);
    do_cmd("ovf_end", ENDC, 0, 0, 1, 8, 0);
    do_cmd("abort", ABORT, 0, 0, 0, 0, 1);
    check("abort_depth", depth, 0);
    do_cmd("empty_end", ENDC, 0, 0, 0, 0, 1);
    check("empty_end_depth", depth, 0);
    check("empty_end_err", err, 1);

    // ---------------- address wrap ----------------
    do_reset();
    cfg_slot(0, 2, lin(1, 0));
    cfg_bases(lin(18'h3FFFF, 0));
    check("wrap_base", addr, lin(18'h3FFFF, 0));
    do_cmd("wrap_start", START, 0, 0, 0, 0, 0);
    do_cmd("wrap_end", ENDC, 0, 0, 1, 1, 0);
    check("wrap_addr", addr, 0);
    check("wrap_err", err, 0);

    // ---------------- config write while a loop is live ----------------
    do_reset();
    cfg_slot(0, 2, lin(1, 0));
    do_cmd("live_start", START, 0, 5, 0, 0, 0);
    cfg_slot(0, 5, lin(7, 0));
    check("live_cfg_err", err, 1);
    do_cmd("live_end1", ENDC, 0, 0, 1, 6, 0);
    check("live_addr", addr, lin(1, 0));
    do_cmd("live_end2", ENDC, 0, 0, 0, 0, 1);
    check("live_depth", depth, 0);

    // ---------------- config write and START on the same edge ----------------
    do_reset();
    cfg_we = 1'b1; cfg_loop = '0; cfg_count = CNT_W'(2); cfg_stride = lin(3, 0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'(START); cmd_if.cmd_loop = '0; cmd_if.cmd_pc = PC_W'(9);
    @(posedge clk); #1;
    cfg_we = 1'b0; cmd_if.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("same_rsp", {cmd_if.rsp_valid, cmd_if.rsp_jump, cmd_if.rsp_done}, 3'b100);
    check("same_err", err, 0);
    check("same_depth", depth, 1);
    @(posedge clk); #1;

    // ---------------- reset during EXEC of an END ----------------
    do_reset();
    cfg_slot(0, 3, lin(4, 0));
    cfg_bases(lin(50, 0));
    do_cmd("mid_start", START, 0, 1, 0, 0, 0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'(ENDC);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    check("mid_in_exec", dbg_state, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_now", {cmd_if.rsp_valid, depth, addr}, 0);
    check("mid_rst_ready", cmd_if.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_rst_hold%0d", i), {cmd_if.rsp_valid, depth, addr, err}, 0);
    end
    reset = 1'b1;
    #1;
    check("mid_rel_ready", cmd_if.cmd_ready, 1);
    @(posedge clk); #1;
    check("mid_rel_ready2", {cmd_if.cmd_ready, cmd_if.rsp_valid}, 2'b10);
    check("mid_rel_addr", addr, 0);

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule
